// File: rtl/act_skew_feeder_if.sv
// Activation input stream: one ROWS-wide vector per beat,
// with a tile-end marker, under a valid/ready handshake.
interface act_skew_feeder_if #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] in_data;
  logic                   in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/act_skew_feeder.sv
// Buffers activation vectors and feeds them diagonally skewed
// into a systolic PE array, one lane per row.
module act_skew_feeder #(
  parameter int ROWS       = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  act_skew_feeder_if.slave       in_if,
  output logic [ROWS*DATA_W-1:0] a_out,
  output logic [ROWS-1:0]        a_vld,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int VW = ROWS * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          done_nx;

  logic [VW-1:0]         mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_l;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;

  logic          full, empty;
  logic          push, pop;
  logic [VW-1:0] head_d;
  logic          head_l;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign in_if.in_ready = !full;

  assign push   = in_if.in_valid && !full;
  assign pop    = (state == STREAM) && !empty;
  assign head_d = mem_d[rd_ptr];
  assign head_l = mem_l[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_d[wr_ptr] <= in_if.in_data;
      mem_l[wr_ptr] <= in_if.in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // DRAIN spends ROWS cycles so the last vector clears every lane
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_nx = STREAM;
      end
      STREAM: begin
        if (pop && head_l) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end
      end
      DRAIN: begin
        if (cnt == CW'(ROWS-1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
    end
  end

  assign busy = (state != IDLE);

  // lane r is a shift chain of r+1 stages; bubbles enter as zero
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_W-1:0] sd [r+1];
    logic [r:0]        sv;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) sd[k] <= '0;
        sv <= '0;
      end else if (clear) begin
        for (int k = 0; k <= r; k++) sd[k] <= '0;
        sv <= '0;
      end else begin
        sd[0] <= pop ? head_d[r*DATA_W +: DATA_W] : '0;
        sv[0] <= pop;
        for (int k = 1; k <= r; k++) begin
          sd[k] <= sd[k-1];
          sv[k] <= sv[k-1];
        end
      end
    end

    assign a_out[r*DATA_W +: DATA_W] = sd[r];
    assign a_vld[r]                  = sv[r];
  end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 The module SHALL have parameter ROWS, default 4, meaning PE array rows fed, one activation lane per row.
REQ-002 The module SHALL have parameter DATA_W, default 8, meaning activation width, matching PE a_in.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, a power of two ≥2, meaning the number of input vectors buffered.
REQ-004 The module SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port clear, input, 1 bit: synchronous flush, aligned with the PE clear.
REQ-007 The module SHALL have port in_valid, input, 1 bit: an input vector is offered.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the FIFO can accept a vector.
REQ-009 The module SHALL have port in_data, input, ROWS*DATA_W bits: one activation vector, element r at bits [r*DATA_W +: DATA_W].
REQ-010 The module SHALL have port in_last, input, 1 bit: marks the final vector of a tile.
REQ-011 The module SHALL have port a_out, output, ROWS*DATA_W bits: skewed activations, lane r drives row-r PE a_in.
REQ-012 The module SHALL have port a_vld, output, ROWS bits: lane r carries real data, not fill.
REQ-013 The module SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-014 The module SHALL have port done, output, 1 bit: a single-cycle pulse when the tile has fully drained.

Function
REQ-015 The module SHALL accept a vector on a clk edge where in_valid && in_ready; in_ready SHALL equal !full, derived from registered FIFO count only, with no combinational path from in_valid.
REQ-016 Each FIFO entry SHALL store in_data plus in_last; on overflow attempt (in_valid while full) nothing SHALL be written and no data SHALL be corrupted.
REQ-017 The FSM SHALL have states IDLE, STREAM, DRAIN; IDLE->STREAM when the FIFO is non-empty.
REQ-018 In STREAM, one vector SHALL be popped per cycle while the FIFO is non-empty; an empty FIFO SHALL inject a bubble (zero data, valid 0) and stay in STREAM.
REQ-019 Skew: for a vector popped on edge t, lane r SHALL present element r with a_vld[r]=1 in the cycle after edge t+r, i.e. lane 0 after one register stage and lane r after r+1 stages.
REQ-020 Bubbles and fill SHALL propagate through the same skew stages, so a_out lane r is 0 whenever a_vld[r]=0.
REQ-021 Popping an entry with last=1 SHALL move the FSM to DRAIN; DRAIN SHALL pop nothing, inject fill for ROWS cycles (counter 0..ROWS-1), then pulse done for 1 cycle and enter IDLE.
REQ-022 Pushes SHALL remain accepted in every state, including DRAIN; buffered vectors SHALL wait until IDLE->STREAM.
REQ-023 Simultaneous push and pop in one cycle SHALL keep the count unchanged, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 clear SHALL take priority over push and pop, empty the FIFO, zero all skew stages and a_vld, force IDLE, and deassert done.
REQ-025 No arithmetic SHALL be applied to activation data; the block SHALL only pass data through and zero-fill.

Reset
REQ-026 While rst=1, FIFO count, pointers, skew registers, a_out, a_vld, busy, done and the DRAIN counter SHALL be 0, and the state SHALL be IDLE.
REQ-027 in_ready SHALL be 1 immediately after rst deasserts, since the FIFO is empty.
REQ-028 Reset asserted mid-tile SHALL discard all buffered and in-flight data, with no done pulse afterwards.

Verification
REQ-029 ROWS=4: push {0x04,0x03,0x02,0x01} (lane3..0), last=1 -> lane0=0x01 one cycle after pop, lane1=0x02 next, lane2=0x03, lane3=0x04; done pulses once; then IDLE.
REQ-030 Push 5 vectors back-to-back with no pop possible (held in DRAIN of a prior tile) -> in_ready=0 after 4; the 5th is held by the producer; all 4 buffered vectors emerge in order.
REQ-031 Push vectors A, then a gap of 2 cycles, then B (last) -> 2 bubble slots with a_vld=0 and a_out=0 appear diagonally between A and B on every lane.
REQ-032 clear asserted while 3 vectors are buffered and 2 are in flight -> next cycle a_vld=0, in_ready=1, busy=0, no done.
REQ-033 rst pulsed during DRAIN -> outputs zero immediately (asynchronous), no done afterwards; a subsequent tile streams correctly.
REQ-034 Continuous streaming at full rate with a 0xFF pattern -> one pop per cycle, FIFO pointers wrap, no data lost, lanes are exactly 1 cycle apart.
